distance_bcd_conv: RTL

//  Converts the signed binary train-to-target distance into per-digit BCD values and a sign flag.

---
 rtl/distance_bcd_conv_pkg.sv | 15 +
 rtl/distance_bcd_conv_if.sv | 36 +++
 rtl/distance_bcd_conv_dd_add3.sv | 11 +
 rtl/distance_bcd_conv.sv | 114 +++++++++++
 4 files changed

// File: rtl/distance_bcd_conv_pkg.sv
// Shared constants and FSM state type for the signed-distance to BCD converter.
// Defaults are shared with the display instantiation so both sides agree on widths.
package distance_bcd_conv_pkg;

   localparam int BCD_W          = 4;
   localparam int DATA_W_DEF     = 16;
   localparam int NUM_DIGITS_DEF = 5;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_CONV   = 2'd1,
      S_COMMIT = 2'd2
   } state_e;

endpackage : distance_bcd_conv_pkg

// File: rtl/distance_bcd_conv_if.sv
// Frame request / result bundle between the frame timing source and the converter.
// The slave side is the converter, the master side is whoever requests conversions.
interface distance_bcd_conv_if #(
   parameter int DATA_W     = 16,
   parameter int NUM_DIGITS = 5
);

   logic                    i_frame_start;
   logic [DATA_W-1:0]       i_distance;
   logic [4*NUM_DIGITS-1:0] o_digits;
   logic [NUM_DIGITS-1:0]   o_digit_en;
   logic                    o_minus;
   logic                    o_valid;
   logic                    o_busy;

   modport master (
      output i_frame_start,
      output i_distance,
      input  o_digits,
      input  o_digit_en,
      input  o_minus,
      input  o_valid,
      input  o_busy
   );

   modport slave (
      input  i_frame_start,
      input  i_distance,
      output o_digits,
      output o_digit_en,
      output o_minus,
      output o_valid,
      output o_busy
   );

endinterface : distance_bcd_conv_if

// File: rtl/distance_bcd_conv_dd_add3.sv
// Double-dabble correction cell: a BCD nibble of 5 or more gets +3 before the shift.
module dd_add3
   import distance_bcd_conv_pkg::*;
(
   input  logic [BCD_W-1:0] din_i,
   output logic [BCD_W-1:0] dout_o
);

   assign dout_o = (din_i >= BCD_W'(5)) ? din_i + BCD_W'(3) : din_i;

endmodule : dd_add3

// File: rtl/distance_bcd_conv.sv
// Iterative signed binary to BCD converter, one conversion per video frame.
// Digits, sign and blanking mask are committed together so the display never tears.
module distance_bcd_conv
   import distance_bcd_conv_pkg::*;
#(
   parameter int DATA_W     = DATA_W_DEF,
   parameter int NUM_DIGITS = NUM_DIGITS_DEF
) (
   input  logic                i_clk,
   input  logic                i_rst,
   distance_bcd_conv_if.slave  bus
);

   localparam int BCD_TOT = BCD_W * NUM_DIGITS;
   localparam int CNT_W   = $clog2(DATA_W + 1);

   state_e                 state_q;
   logic                   sign_q;
   logic [DATA_W-1:0]      mag_q;
   logic [BCD_TOT-1:0]     bcd_q;
   logic [CNT_W-1:0]       cnt_q;

   logic [BCD_TOT-1:0]     digits_q;
   logic [NUM_DIGITS-1:0]  digit_en_q;
   logic                   minus_q;
   logic                   valid_q;
   logic                   busy_q;

   logic [DATA_W-1:0]         mag_d;
   logic [BCD_TOT-1:0]        bcd_adj;
   logic [BCD_TOT+DATA_W-1:0] shift_d;
   logic [NUM_DIGITS-1:0]     digit_en_d;

   // Magnitude in DATA_W unsigned bits: the most negative value maps onto itself, which is correct.
   assign mag_d   = bus.i_distance[DATA_W-1] ? (~bus.i_distance + DATA_W'(1)) : bus.i_distance;
   assign shift_d = {bcd_adj, mag_q} << 1;

   generate
      for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_add3
         dd_add3 u_add3 (
            .din_i  (bcd_q[gi*BCD_W +: BCD_W]),
            .dout_o (bcd_adj[gi*BCD_W +: BCD_W])
         );
      end
   endgenerate

   // Leading-zero blanking: a digit shows if it or any higher digit is nonzero; ones always shows.
   assign digit_en_d[0] = 1'b1;
   generate
      for (genvar gi = 1; gi < NUM_DIGITS; gi++) begin : g_blank
         if (gi == NUM_DIGITS - 1) begin : g_top
            assign digit_en_d[gi] = |bcd_q[gi*BCD_W +: BCD_W];
         end else begin : g_mid
            assign digit_en_d[gi] = (|bcd_q[gi*BCD_W +: BCD_W]) | digit_en_d[gi+1];
         end
      end
   endgenerate

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= S_IDLE;
         sign_q     <= 1'b0;
         mag_q      <= '0;
         bcd_q      <= '0;
         cnt_q      <= '0;
         digits_q   <= '0;
         digit_en_q <= NUM_DIGITS'(1);
         minus_q    <= 1'b0;
         valid_q    <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (bus.i_frame_start) begin
                  sign_q  <= bus.i_distance[DATA_W-1];
                  mag_q   <= mag_d;
                  bcd_q   <= '0;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= S_CONV;
               end
            end
            S_CONV: begin
               bcd_q <= shift_d[BCD_TOT+DATA_W-1:DATA_W];
               mag_q <= shift_d[DATA_W-1:0];
               cnt_q <= cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(DATA_W - 1)) begin
                  state_q <= S_COMMIT;
               end
            end
            S_COMMIT: begin
               digits_q   <= bcd_q;
               digit_en_q <= digit_en_d;
               minus_q    <= sign_q;
               valid_q    <= 1'b1;
               busy_q     <= 1'b0;
               state_q    <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.o_digits   = digits_q;
   assign bus.o_digit_en = digit_en_q;
   assign bus.o_minus    = minus_q;
   assign bus.o_valid    = valid_q;
   assign bus.o_busy     = busy_q;

endmodule : distance_bcd_conv
